// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one aligned byte/half/word access from the pipeline,
// runs it on a simple req/ack bus with a timeout, and returns extended load data.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  inst_size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mreq,
    output logic        mwrite,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    output logic [3:0]  mbe,
    input  logic        mack,
    input  logic [31:0] mrdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [1:0]      addr_lo;
    logic [1:0]      size_q;
    logic            uns_q;
    logic            err_q;
    logic            req, aligned, legal, limit;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [31:0]     load_val;

    assign req     = mem_read | mem_write;
    assign aligned = (inst_size == 2'b00) ||
                     (inst_size == 2'b01 && !addr[0]) ||
                     (inst_size == 2'b10 && addr[1:0] == 2'b00);
    assign legal   = (mem_read ^ mem_write) && aligned;
    // cnt holds the 1-based index of the current BUSY cycle.
    assign limit   = (cnt == CW'(TIMEOUT));

    assign lane_b = mrdata[{addr_lo, 3'b000} +: 8];
    assign lane_h = mrdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        load_val = mrdata;
        case (size_q)
            2'b00:   load_val = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_val = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_val = mrdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                stall = legal;
                if (legal)    state_next = BUSY;
                else if (req) state_next = DONE;
            end
            BUSY: begin
                stall = 1'b1;
                if (mack || limit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                err        = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mreq    <= 1'b0;
            mwrite  <= 1'b0;
            maddr   <= '0;
            mwdata  <= '0;
            mbe     <= '0;
            rdata   <= '0;
            cnt     <= '0;
            addr_lo <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (state == IDLE) begin
            if (legal) begin
                mreq    <= 1'b1;
                mwrite  <= mem_write;
                maddr   <= {addr[31:2], 2'b00};
                cnt     <= CW'(1);
                addr_lo <= addr[1:0];
                size_q  <= inst_size;
                uns_q   <= load_unsigned;
                err_q   <= 1'b0;
                case (inst_size)
                    2'b00: begin
                        mwdata <= {4{wdata[7:0]}};
                        mbe    <= 4'b0001 << addr[1:0];
                    end
                    2'b01: begin
                        mwdata <= {2{wdata[15:0]}};
                        mbe    <= 4'b0011 << {addr[1], 1'b0};
                    end
                    default: begin
                        mwdata <= wdata;
                        mbe    <= 4'b1111;
                    end
                endcase
            end else if (req) begin
                err_q <= 1'b1;
                rdata <= '0;
            end
        end else if (state == BUSY) begin
            if (mack || limit) begin
                mreq   <= 1'b0;
                mwrite <= 1'b0;
                mbe    <= '0;
            end
            if (mack) begin
                err_q <= 1'b0;
                if (!mwrite) rdata <= load_val;
            end else if (limit) begin
                err_q <= 1'b1;
                rdata <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit with a scoreboard of expected completions;
// adds hand-written sequences for reset state and mid-access reset abort.
module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, load_unsigned = 1'b0;
    logic [1:0]  inst_size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        mreq, mwrite, mack = 1'b0;
    logic [31:0] maddr, mwdata, mrdata = '0, rdata;
    logic [3:0]  mbe;
    logic        stall, done, err;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_read(mem_read), .mem_write(mem_write), .inst_size(inst_size),
        .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
        .mreq(mreq), .mwrite(mwrite), .maddr(maddr), .mwdata(mwdata), .mbe(mbe),
        .mack(mack), .mrdata(mrdata),
        .rdata(rdata), .stall(stall), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr, wdata, mrdata, exp_rdata;
        logic [3:0]  exp_mbe;
        logic [31:0] exp_mwdata;
        bit          ok;
        int          delay;   // BUSY cycles before mack; negative means never
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0, fails = 0;
    logic [31:0] model_rdata = '0;
    vec_t        vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] size,
                                input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] mrd, input logic [31:0] erd,
                                input logic [3:0] ebe, input logic [31:0] ewd,
                                input bit ok, input int delay);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.uns = uns; v.addr = a; v.wdata = wd;
        v.mrdata = mrd; v.exp_rdata = erd; v.exp_mbe = ebe; v.exp_mwdata = ewd;
        v.ok = ok; v.delay = delay;
        return v;
    endfunction

    task automatic run_access(input vec_t v);
        int   exp_busy;
        bit   timeout;
        exp_t e, got;
        timeout  = v.ok && (v.delay < 0 || v.delay >= TIMEOUT);
        exp_busy = !v.ok ? 0 : (timeout ? TIMEOUT : v.delay + 1);
        e.err    = !v.ok || timeout;
        if (e.err)     model_rdata = '0;
        else if (v.rd) model_rdata = v.exp_rdata;
        e.rdata = model_rdata;
        sb.push_back(e);

        @(posedge clk); #1;
        mem_read = v.rd; mem_write = v.wr; inst_size = v.size; load_unsigned = v.uns;
        addr = v.addr; wdata = v.wdata; mrdata = v.mrdata;
        mack = (v.delay == 0);
        @(negedge clk);
        check("done_before", done, 1'b0);
        check("stall_req", stall, v.ok);

        for (int cyc = 0; cyc <= exp_busy; cyc++) begin
            @(posedge clk); #1;
            // Scramble request inputs: they must be ignored outside IDLE.
            mem_read = 1'($urandom); mem_write = 1'($urandom);
            inst_size = 2'($urandom); load_unsigned = 1'($urandom);
            addr = $urandom; wdata = $urandom;
            mack = (v.delay >= 0 && cyc >= v.delay);
            @(negedge clk);
            check("mreq", mreq, cyc < exp_busy);
            check("stall", stall, cyc < exp_busy);
            check("done", done, cyc == exp_busy);
            check("err", err, (cyc == exp_busy) && e.err);
            if (cyc < exp_busy) begin
                check("mwrite", mwrite, v.wr);
                check("maddr", maddr, {v.addr[31:2], 2'b00});
                check("mbe", mbe, v.exp_mbe);
                if (v.wr) check("mwdata", mwdata, v.exp_mwdata);
            end else begin
                check("mbe_off", mbe, 4'b0000);
            end
        end
        got.err = err;
        got.rdata = rdata;
        mem_read = 1'b0; mem_write = 1'b0; mack = 1'b0;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("sb_err", got.err, e.err);
            check("sb_rdata", got.rdata, e.rdata);
        end
    endtask

    initial begin
        //         rd   wr   size  uns  addr          wdata         mrdata        exp_rdata     mbe      mwdata        ok delay
        vecs[0]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 32'h0,        1, 0);
        vecs[1]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_FF00, 32'hFFFF_FF80, 4'b1000, 32'h0,        1, 0);
        vecs[2]  = mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        32'h80FF_FF00, 32'h0000_0080, 4'b1000, 32'h0,        1, 0);
        vecs[3]  = mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 32'h0,        4'b1100, 32'hABCD_ABCD, 1, 0);
        vecs[4]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        0, 0);
        vecs[5]  = mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 32'hFFFF_8001, 4'b1100, 32'h0,        1, 3);
        vecs[6]  = mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0,        32'h1234_F00D, 32'h0000_F00D, 4'b0011, 32'h0,        1, 0);
        vecs[7]  = mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0305, 32'h0000_00A5, 32'h0,        32'h0,        4'b0010, 32'hA5A5_A5A5, 1, 2);
        vecs[8]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0,        32'h1122_3344, 32'h0000_0033, 4'b0010, 32'h0,        1, 1);
        vecs[9]  = mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0200, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        0, 0);
        vecs[10] = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        0, 0);
        vecs[11] = mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0103, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        0, 0);
        vecs[12] = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,        32'h0,        4'b1111, 32'hCAFE_F00D, 1, 0);
        vecs[13] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0,        32'h1111_2222, 32'h0,        4'b1111, 32'h0,        1, -1);
        vecs[14] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0604, 32'h0,        32'h0BAD_F00D, 32'h0BAD_F00D, 4'b1111, 32'h0,        1, TIMEOUT - 1);
        vecs[15] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0608, 32'h0,        32'h7777_7777, 32'h0,        4'b1111, 32'h0,        1, TIMEOUT);

        #12;
        check("rst_mreq", mreq, 1'b0);
        check("rst_mwrite", mwrite, 1'b0);
        check("rst_mbe", mbe, 4'b0000);
        check("rst_maddr", maddr, 32'h0);
        check("rst_mwdata", mwdata, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_stall", stall, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) run_access(vecs[i]);

        // Reset in the middle of a BUSY access aborts it without done or err.
        @(posedge clk); #1;
        mem_read = 1'b1; inst_size = 2'b10; addr = 32'h0000_0700; mack = 1'b0;
        @(posedge clk); #1;
        mem_read = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_busy_mreq", mreq, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_mreq", mreq, 1'b0);
        check("abort_stall", stall, 1'b0);
        check("abort_mbe", mbe, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_done", done, 1'b0);
            check("abort_err", err, 1'b0);
        end
        reset_n = 1'b1;
        model_rdata = '0;
        check("abort_rdata", rdata, 32'h0);
        run_access(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0800, 32'h1357_9BDF, 32'h0, 32'h0,
                      4'b1111, 32'h1357_9BDF, 1, 1));
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum BUSY cycles to wait for mack before a bus error.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port mem_read, input, 1: load request from the decode/control stage.
REQ-005 SHALL have port mem_write, input, 1: store request from the decode/control stage.
REQ-006 SHALL have port inst_size, input, 2: access size, 00=byte, 01=half, 10=word, 11=illegal.
REQ-007 SHALL have port load_unsigned, input, 1: inst[14] (funct3[2]); 1 selects zero-extension (lbu/lhu).
REQ-008 SHALL have port addr, input, 32: effective address from the ALU.
REQ-009 SHALL have port wdata, input, 32: store data (rs2).
REQ-010 SHALL have bus output ports mreq 1, mwrite 1, maddr 32 (word-aligned), mwdata 32 and mbe 4 (byte enables).
REQ-011 SHALL have bus input ports mack 1 and mrdata 32.
REQ-012 SHALL have port rdata, output, 32: aligned, extended load result.
REQ-013 SHALL have port stall, output, 1: holds the pipeline while an access is pending.
REQ-014 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port err, output, 1: one-cycle error pulse (misaligned, illegal or timeout).

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 IDLE transition: a valid request (mem_read XOR mem_write, legal size, aligned) SHALL latch addr, size, load_unsigned, wdata and direction, then move to BUSY.
REQ-018 Alignment rules SHALL be: half requires addr[0]=0; word requires addr[1:0]=00; inst_size=11 is illegal.
REQ-019 An illegal request in IDLE (misaligned, size 11, or mem_read and mem_write both 1) SHALL go to DONE with err=1, issue no mreq and leave rdata=0.
REQ-020 stall SHALL be combinational: 1 when (IDLE and mem_read or mem_write, request legal) or BUSY; 0 in DONE.
REQ-021 mreq and mwrite SHALL be registered, asserted for every BUSY cycle, and deasserted in the cycle after mack is sampled.
REQ-022 maddr SHALL equal {addr[31:2],2'b00}.
REQ-023 mbe SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; mbe SHALL be 0 when mreq=0.
REQ-024 mwdata SHALL be: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-025 BUSY with mack=1 on a load SHALL select the lane of mrdata by addr[1:0], sign- or zero-extend it per load_unsigned, register the result into rdata, and go to DONE.
REQ-026 BUSY with mack=1 on a store SHALL go to DONE with rdata unchanged.
REQ-027 A BUSY cycle counter SHALL reset on BUSY entry; when it reaches TIMEOUT with mack=0 the FSM SHALL go to DONE with err=1, and mreq SHALL drop.
REQ-028 mack sampled in the same cycle the counter reaches TIMEOUT SHALL count as success, with no err.
REQ-029 mack outside BUSY SHALL be ignored.
REQ-030 DONE SHALL assert done=1 for exactly one cycle and return to IDLE unconditionally.
REQ-031 Back-to-back: a request present in the IDLE cycle after DONE SHALL be accepted.
REQ-032 Latency SHALL be: zero-wait bus gives done 2 cycles after acceptance (accept, BUSY+mack, DONE).
REQ-033 Inputs SHALL be ignored outside IDLE; latched values govern the whole access.

Reset
REQ-034 reset_n=0 SHALL immediately force IDLE, clear the counter, and set mreq=0, mwrite=0, mbe=0, maddr=0, mwdata=0, rdata=0, done=0, err=0.
REQ-035 Reset asserted mid-access SHALL abort the access with no done or err pulse; after reset_n rises, the first request SHALL be accepted normally.

Verification
REQ-036 lw addr=0x100, mack on first BUSY cycle, mrdata=0xDEADBEEF -> maddr=0x100, mbe=1111, rdata=0xDEADBEEF, done 2 cycles after accept.
REQ-037 lb addr=0x103, mrdata=0x80FF_FF00 -> mbe=1000, rdata=0xFFFFFF80; same access as lbu -> rdata=0x00000080.
REQ-038 sh addr=0x202, wdata=0x1234ABCD -> mwrite=1, mbe=1100, mwdata=0xABCDABCD, done pulse, rdata unchanged.
REQ-039 lw addr=0x101 -> no mreq ever, err=1 and done=1 in the next cycle, stall=0 throughout.
REQ-040 lw with mack held 0 -> mreq high exactly 16 cycles, then err=1 and done=1, rdata=0; variant with mack at cycle 16 -> success, err=0.
REQ-041 reset_n pulsed low during BUSY -> mreq=0 and stall=0 at once, no done; subsequent sw completes normally.
